// File: rtl/paillier_result_drain_if.sv
// paillier_result_drain_if: write-burst request and data-beat bus between the result drain (master) and the AXI write engine (slave)
interface paillier_result_drain_if #(
  parameter int K = 128
);
  logic burst_valid;
  logic burst_ready;
  logic [63:0] burst_addr;
  logic [7:0] burst_len;
  logic [K-1:0] wdata;
  logic wvalid;
  logic wready;
  logic wlast;
  modport master (
    output burst_valid, burst_addr, burst_len, wdata, wvalid, wlast,
    input burst_ready, wready
  );
  modport slave (
    input burst_valid, burst_addr, burst_len, wdata, wvalid, wlast,
    output burst_ready, wready
  );
endinterface

// File: rtl/paillier_result_drain.sv
// paillier_result_drain: round-robin drain of BLOCK_COUNT result FIFOs (rd_rdy/rd_dout/rd_cnt) into N-beat write bursts on wr, start/done per run
module paillier_result_drain #(
  parameter int BLOCK_COUNT = 25,
  parameter int TEST_TIMES = 18,
  parameter int K = 128,
  parameter int N = 32,
  parameter logic [63:0] TARGET_WR_ADDR = 64'h1_0000_0000
) (
  input logic M_AXI_ACLK,
  input logic M_AXI_ARESETN,
  input logic start,
  output logic done,
  output logic [BLOCK_COUNT-1:0] rd_rdy,
  input logic [BLOCK_COUNT*K-1:0] rd_dout,
  input logic [BLOCK_COUNT*($clog2(N)+1)-1:0] rd_cnt,
  paillier_result_drain_if.master wr
);
  localparam int CW = $clog2(N) + 1;
  localparam int SW = BLOCK_COUNT > 1 ? $clog2(BLOCK_COUNT) : 1;
  localparam int IW = $clog2(TEST_TIMES + 1);
  localparam int TW = $clog2(BLOCK_COUNT * TEST_TIMES + 1);
  localparam int BW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, SCAN, ADDR, DATA, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] iter [BLOCK_COUNT];
  logic [TW-1:0] total;
  logic [SW-1:0] rr_ptr, sel, pick;
  logic [SW:0] cand;
  logic [BW-1:0] beat;
  logic [BLOCK_COUNT-1:0] elig;
  logic found, arm, last_acc;
  assign arm = start && (state == IDLE || state == DONE);
  assign last_acc = state == DATA && wr.wready && beat == BW'(N - 1);
  always_comb begin
    elig = '0;
    found = 1'b0;
    pick = '0;
    cand = '0;
    for (int i = 0; i < BLOCK_COUNT; i++) elig[i] = rd_cnt[i*CW +: CW] >= CW'(N) && iter[i] < IW'(TEST_TIMES);
    for (int o = 0; o < BLOCK_COUNT; o++) begin
      cand = {1'b0, rr_ptr} + (SW+1)'(o);
      cand = cand >= (SW+1)'(BLOCK_COUNT) ? cand - (SW+1)'(BLOCK_COUNT) : cand;
      if (!found && elig[cand[SW-1:0]]) begin
        found = 1'b1;
        pick = cand[SW-1:0];
      end
    end
  end
  always_ff @(posedge M_AXI_ACLK) state <= !M_AXI_ARESETN ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? SCAN : state;
      SCAN: state_n = found ? ADDR : SCAN;
      ADDR: state_n = wr.burst_ready ? DATA : ADDR;
      DATA: state_n = !last_acc ? DATA : total == TW'(BLOCK_COUNT * TEST_TIMES - 1) ? DONE : SCAN;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    done = state == DONE;
    wr.burst_valid = state == ADDR;
    wr.burst_addr = state == ADDR ? TARGET_WR_ADDR + (64'(sel) * 64'(TEST_TIMES) + 64'(iter[sel])) * 64'(N * K / 8) : '0;
    wr.burst_len = state == ADDR ? 8'(N - 1) : '0;
    wr.wvalid = state == DATA;
    wr.wdata = state == DATA ? rd_dout[int'(sel)*K +: K] : '0;
    wr.wlast = state == DATA && beat == BW'(N - 1);
    rd_rdy = state == DATA && wr.wready ? BLOCK_COUNT'(1) << sel : '0;
  end
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN || arm) begin
      for (int i = 0; i < BLOCK_COUNT; i++) iter[i] <= '0;
      total <= '0;
      rr_ptr <= '0;
      if (!M_AXI_ARESETN) begin
        sel <= '0;
        beat <= '0;
      end
    end else begin
      if (state == SCAN && found) sel <= pick;
      if (state == ADDR && wr.burst_ready) beat <= '0;
      if (state == DATA && wr.wready) beat <= beat + 1'b1;
      if (last_acc) begin
        iter[sel] <= iter[sel] + 1'b1;
        total <= total + 1'b1;
        rr_ptr <= sel == SW'(BLOCK_COUNT - 1) ? '0 : sel + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_paillier_result_drain.sv
// tb_paillier_result_drain: randomized scoreboard bench for paillier_result_drain with FIFO models and a round-robin reference
module tb_paillier_result_drain;
  localparam int BC = 25;
  localparam int TT = 18;
  localparam int K = 128;
  localparam int N = 32;
  localparam int CW = 6;
  localparam logic [63:0] BASE = 64'h1_0000_0000;
  typedef struct {
    logic [K-1:0] d;
    logic l;
    int b;
  } beat_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic done;
  logic [BC-1:0] rd_rdy;
  logic [BC*K-1:0] rd_dout = '0;
  logic [BC*CW-1:0] rd_cnt = '0;
  logic [BC-1:0] pop_mask = '0;
  logic [K-1:0] fq [BC][$];
  logic [K-1:0] mq [BC][$];
  logic [63:0] exp_addr [$];
  beat_t exp_beat [$];
  int m_iter [BC];
  int m_rr, m_total, n_chk, n_fail, beats_seen, wmode;
  paillier_result_drain_if #(.K(K)) wr();
  paillier_result_drain dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rstn),
    .start(start),
    .done(done),
    .rd_rdy(rd_rdy),
    .rd_dout(rd_dout),
    .rd_cnt(rd_cnt),
    .wr(wr)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    pop_mask = rd_rdy;
    if (rstn) begin
      if (wr.burst_valid && wr.burst_ready) begin
        chk("burst_pending", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("burst_addr", wr.burst_addr, exp_addr.pop_front());
        chk("burst_len", wr.burst_len, N - 1);
      end
      if (wr.wvalid && wr.wready) begin
        beats_seen++;
        chk("beat_pending", exp_beat.size() > 0, 1);
        if (exp_beat.size() > 0) begin
          beat_t e;
          logic [BC-1:0] one;
          e = exp_beat.pop_front();
          one = 1;
          chk("wdata", wr.wdata, e.d);
          chk("wlast", wr.wlast, e.l);
          chk("rd_rdy_pop", rd_rdy, one << e.b);
        end
      end else chk("rd_rdy_idle", rd_rdy, 0);
    end
  end
  task automatic refresh();
    for (int i = 0; i < BC; i++) begin
      rd_cnt[i*CW +: CW] = fq[i].size() > 63 ? 6'd63 : CW'(fq[i].size());
      rd_dout[i*K +: K] = fq[i].size() > 0 ? fq[i][0] : '0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < BC; i++) if (pop_mask[i] === 1'b1 && fq[i].size() > 0) void'(fq[i].pop_front());
    wr.wready = wmode == 0 ? 1'b1 : wmode == 1 ? ~wr.wready : ($urandom_range(3) != 0);
    wr.burst_ready = wmode == 2 ? 1'($urandom_range(1)) : 1'b1;
    refresh();
  endtask
  task automatic load(int b, int words);
    logic [K-1:0] d;
    for (int w = 0; w < words; w++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      fq[b].push_back(d);
      mq[b].push_back(d);
    end
  endtask
  task automatic plan();
    int j;
    while (m_total < BC * TT) begin
      j = -1;
      for (int o = 0; o < BC; o++) begin
        int c;
        c = (m_rr + o) % BC;
        if (j < 0 && mq[c].size() >= N && m_iter[c] < TT) j = c;
      end
      if (j < 0) break;
      exp_addr.push_back(BASE + 64'((j * TT + m_iter[j]) * (N * K / 8)));
      for (int w = 0; w < N; w++) exp_beat.push_back('{mq[j].pop_front(), w == N - 1, j});
      m_iter[j]++;
      m_total++;
      m_rr = (j + 1) % BC;
    end
  endtask
  task automatic start_run();
    for (int i = 0; i < BC; i++) m_iter[i] = 0;
    m_rr = 0;
    m_total = 0;
    plan();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic drain(int budget);
    int c;
    c = 0;
    while ((exp_addr.size() > 0 || exp_beat.size() > 0) && c < budget) begin
      tick();
      c++;
    end
    chk("drain_left", exp_addr.size() + exp_beat.size(), 0);
    repeat (4) tick();
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_burst_valid"}, wr.burst_valid, 0);
    chk({tag, "_burst_addr"}, wr.burst_addr, 0);
    chk({tag, "_burst_len"}, wr.burst_len, 0);
    chk({tag, "_wvalid"}, wr.wvalid, 0);
    chk({tag, "_wlast"}, wr.wlast, 0);
    chk({tag, "_wdata"}, wr.wdata, 0);
    chk({tag, "_rd_rdy"}, rd_rdy, 0);
  endtask
  initial begin
    int base, c;
    wr.burst_ready = 1'b0;
    wr.wready = 1'b0;
    wmode = 0;
    repeat (3) tick();
    check_zero("reset");
    rstn = 1'b1;
    load(0, 32);
    refresh();
    repeat (10) begin
      tick();
      chk("no_start_burst", wr.burst_valid, 0);
    end
    load(1, 32);
    refresh();
    start_run();
    drain(2000);
    chk("single_not_done", done, 0);
    wmode = 1;
    load(5, 32);
    refresh();
    plan();
    drain(2000);
    wmode = 0;
    load(0, 64);
    load(3, 64);
    load(24, 64);
    refresh();
    plan();
    drain(4000);
    chk("rr_not_done", done, 0);
    wmode = 2;
    for (int b = 0; b < BC; b++) load(b, (TT - m_iter[b] + 1) * N);
    refresh();
    plan();
    drain(45000);
    repeat (10) tick();
    chk("run_done", done, 1);
    for (int b = 0; b < BC; b++) chk("surplus_kept", fq[b].size(), mq[b].size());
    wmode = 0;
    start_run();
    chk("rearm_done_clear", done, 0);
    base = beats_seen;
    c = 0;
    while (beats_seen < base + 10 && c < 500) begin
      tick();
      c++;
    end
    chk("beat10_reached", beats_seen >= base + 10, 1);
    rstn = 1'b0;
    tick();
    check_zero("mid_reset");
    tick();
    exp_addr.delete();
    exp_beat.delete();
    for (int b = 0; b < BC; b++) mq[b] = fq[b];
    rstn = 1'b1;
    load(0, 32);
    refresh();
    start_run();
    drain(4000);
    chk("resend_not_done", done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
